// File: rtl/sipo_pkg.sv
// Shared helpers for the SIPO packer: pack order, beat-to-slot mapping and keep-mask update.
package sipo_pkg;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } pack_order_e;

    // Upper bound on MAX_NUM supported by the keep-mask helper.
    localparam int unsigned MAX_SLOTS = 32;

    function automatic int unsigned slot_idx(
        input int unsigned cnt,
        input int unsigned max_num,
        input pack_order_e order
    );
        return (order == MSB_FIRST) ? (max_num - 1 - cnt) : cnt;
    endfunction

    function automatic logic [MAX_SLOTS-1:0] keep_set(
        input logic [MAX_SLOTS-1:0] keep,
        input int unsigned          slot
    );
        return keep | (MAX_SLOTS'(1) << slot);
    endfunction

endpackage

// File: rtl/sipo_packer_if.sv
// Narrow-in / wide-out stream bundle for the SIPO packer; slave is the packer side.
interface sipo_packer_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_NUM = 4
);
    logic [WIDTH-1:0]         s_data;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic [WIDTH*MAX_NUM-1:0] m_data;
    logic [MAX_NUM-1:0]       m_keep;
    logic                     m_last;
    logic                     m_valid;
    logic                     m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_keep, m_last, m_valid
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_keep, m_last, m_valid
    );
endinterface

// File: rtl/sipo_out_slice.sv
// Output holding register: captures a payload on load and keeps it until the consumer takes it.
module sipo_out_slice #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_ready,
    input  logic [PAYLOAD_W-1:0] i_data,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_data
);
    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_data;

    // Load wins over consume so a word accepted on the same edge as a new one is replaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/sipo_packer.sv
// Serial-to-parallel packer: gathers up to MAX_NUM beats into one word, closing early on s_last.
module sipo_packer #(
    parameter int WIDTH     = 8,
    parameter int MAX_NUM   = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    sipo_packer_if.slave bus
);
    import sipo_pkg::*;

    localparam int PW = WIDTH * MAX_NUM;
    localparam int CW = $clog2(MAX_NUM);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_NUM - 1);
    localparam pack_order_e ORDER = pack_order_e'(MSB_FIRST);

    logic [PW-1:0]        r_acc;
    logic [MAX_NUM-1:0]   r_keep;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_slot;
    logic [PW-1:0]        w_accNext;
    logic [MAX_NUM-1:0]   w_keepNext;
    logic                 w_sReady;
    logic                 w_beat;
    logic                 w_complete;
    logic                 w_outValid;
    logic [PW+MAX_NUM:0]  w_outWord;

    // Ready ignores cnt so any accepted beat may safely be the one that completes a word.
    assign w_sReady   = !rst && (!w_outValid || bus.m_ready);
    assign w_beat     = bus.s_valid && w_sReady;
    assign w_complete = w_beat && (bus.s_last || (r_cnt == LAST_CNT));
    assign w_slot     = CW'(slot_idx(32'(r_cnt), 32'(MAX_NUM), ORDER));

    always_comb begin
        w_accNext = r_acc;
        w_accNext[int'(w_slot) * WIDTH +: WIDTH] = bus.s_data;
        w_keepNext = MAX_NUM'(keep_set(MAX_SLOTS'(r_keep), 32'(w_slot)));
    end

    always_ff @(posedge clk) begin
        if (rst || w_complete) begin
            r_acc  <= '0;
            r_keep <= '0;
            r_cnt  <= '0;
        end else if (w_beat) begin
            r_acc  <= w_accNext;
            r_keep <= w_keepNext;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    sipo_out_slice #(
        .PAYLOAD_W(PW + MAX_NUM + 1)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_complete),
        .i_ready (bus.m_ready),
        .i_data  ({bus.s_last, w_keepNext, w_accNext}),
        .o_valid (w_outValid),
        .o_data  (w_outWord)
    );

    assign bus.s_ready = w_sReady;
    assign bus.m_valid = w_outValid;
    assign bus.m_data  = w_outWord[PW-1:0];
    assign bus.m_keep  = w_outWord[PW +: MAX_NUM];
    assign bus.m_last  = w_outWord[PW + MAX_NUM];
endmodule

// File: tb/tb_sipo_packer.sv
// Directed bench for sipo_packer: LSB-first and MSB-first instances driven with identical stimulus.
module tb_sipo_packer;

    typedef struct {
        logic        v;
        logic        l;
        logic [7:0]  d;
        logic        mr;
        logic        expSReady;
        logic        expValid;
        logic [31:0] expData;
        logic [3:0]  expKeep;
        logic        expLast;
        logic        chkMsb;
        logic [31:0] expMsbData;
        logic [3:0]  expMsbKeep;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   idx;
    int   words;
    int   holdLeft;
    logic mr;
    vec_t vecs[$];
    vec_t resetVecs[$];
    logic [31:0] expWords[3];

    sipo_packer_if #(.WIDTH(8), .MAX_NUM(4)) lsbIf ();
    sipo_packer_if #(.WIDTH(8), .MAX_NUM(4)) msbIf ();

    sipo_packer #(.WIDTH(8), .MAX_NUM(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (lsbIf.slave)
    );

    sipo_packer #(.WIDTH(8), .MAX_NUM(4), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (msbIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(
        input logic v, input logic l, input logic [7:0] d, input logic mrIn,
        input logic sr, input logic ev, input logic [31:0] ed, input logic [3:0] ek,
        input logic el, input logic cm, input logic [31:0] emd, input logic [3:0] emk
    );
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.mr = mrIn;
        r.expSReady = sr; r.expValid = ev; r.expData = ed; r.expKeep = ek;
        r.expLast = el; r.chkMsb = cm; r.expMsbData = emd; r.expMsbKeep = emk;
        return r;
    endfunction

    task automatic driveInputs(input logic v, input logic l, input logic [7:0] d, input logic mrIn);
        lsbIf.s_valid = v; lsbIf.s_last = l; lsbIf.s_data = d; lsbIf.m_ready = mrIn;
        msbIf.s_valid = v; msbIf.s_last = l; msbIf.s_data = d; msbIf.m_ready = mrIn;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle: drive, check the combinational ready, clock, then check the registered word.
    task automatic applyStimulus(input vec_t vv, input string tag);
        driveInputs(vv.v, vv.l, vv.d, vv.mr);
        #1;
        checkOutput({tag, " s_ready"}, 32'(lsbIf.s_ready), 32'(vv.expSReady));
        @(posedge clk);
        #1;
        checkOutput({tag, " m_valid"}, 32'(lsbIf.m_valid), 32'(vv.expValid));
        if (vv.expValid) begin
            checkOutput({tag, " m_data"}, lsbIf.m_data, vv.expData);
            checkOutput({tag, " m_keep"}, 32'(lsbIf.m_keep), 32'(vv.expKeep));
            checkOutput({tag, " m_last"}, 32'(lsbIf.m_last), 32'(vv.expLast));
        end
        if (vv.chkMsb) begin
            checkOutput({tag, " msb m_valid"}, 32'(msbIf.m_valid), 32'(vv.expValid));
            checkOutput({tag, " msb m_data"}, msbIf.m_data, vv.expMsbData);
            checkOutput({tag, " msb m_keep"}, 32'(msbIf.m_keep), 32'(vv.expMsbKeep));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " m_valid"}, 32'(lsbIf.m_valid), 32'h0);
        checkOutput({tag, " m_data"}, lsbIf.m_data, 32'h0);
        checkOutput({tag, " m_keep"}, 32'(lsbIf.m_keep), 32'h0);
        checkOutput({tag, " m_last"}, 32'(lsbIf.m_last), 32'h0);
        checkOutput({tag, " msb m_valid"}, 32'(msbIf.m_valid), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //                 v  l  d      mr sr ev data           keep  last msb msbData        msbKeep
        vecs.push_back(mkVec(1, 0, 8'h11, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 0, 8'h22, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 0, 8'h33, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 0, 8'h44, 1, 1, 1, 32'h44332211,  4'hF, 0, 1, 32'h11223344,  4'hF));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 0, 32'h0,         4'h0, 0, 1, 32'h11223344,  4'hF));
        vecs.push_back(mkVec(1, 0, 8'hAA, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 1, 8'hBB, 1, 1, 1, 32'h0000BBAA,  4'h3, 1, 1, 32'hAABB0000,  4'hC));
        vecs.push_back(mkVec(1, 0, 8'hCC, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 1, 8'hDD, 1, 1, 1, 32'h0000DDCC,  4'h3, 1, 1, 32'hCCDD0000,  4'hC));
        vecs.push_back(mkVec(1, 1, 8'h5A, 1, 1, 1, 32'h0000005A,  4'h1, 1, 1, 32'h5A000000,  4'h8));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 0, 8'h01, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 0, 8'h02, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        for (int g = 0; g < 5; g++)
            vecs.push_back(mkVec(0, 0, 8'hEE, 1, 1, 0, 32'h0,     4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 0, 8'h03, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));
        vecs.push_back(mkVec(1, 0, 8'h04, 1, 1, 1, 32'h04030201,  4'hF, 0, 1, 32'h01020304,  4'hF));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0,         4'h0));

        resetVecs.push_back(mkVec(1, 0, 8'h10, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0, 4'h0));
        resetVecs.push_back(mkVec(1, 0, 8'h11, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0, 4'h0));
        resetVecs.push_back(mkVec(1, 0, 8'h12, 1, 1, 0, 32'h0,         4'h0, 0, 0, 32'h0, 4'h0));
        resetVecs.push_back(mkVec(1, 0, 8'h13, 1, 1, 1, 32'h13121110,  4'hF, 0, 0, 32'h0, 4'h0));

        expWords[0] = 32'h04030201;
        expWords[1] = 32'h08070605;
        expWords[2] = 32'h0C0B0A09;

        // Reset held for two edges with a beat offered: nothing may be accepted.
        rst = 1'b1;
        driveInputs(1'b1, 1'b0, 8'h77, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput($sformatf("reset%0d s_ready", c), 32'(lsbIf.s_ready), 32'h0);
            @(posedge clk);
            #1;
            checkAllZero($sformatf("reset%0d", c));
        end
        rst = 1'b0;
        driveInputs(1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        checkOutput("post-reset s_ready", 32'(lsbIf.s_ready), 32'h1);

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 12 back-to-back beats, consumer stalls 6 cycles on the first word.
        idx = 0;
        words = 0;
        holdLeft = 6;
        for (int cyc = 0; cyc < 100 && words < 3; cyc++) begin
            mr = !(lsbIf.m_valid && holdLeft > 0);
            driveInputs(idx < 12, 1'b0, 8'(idx + 1), mr);
            #1;
            if (!mr) begin
                checkOutput("bp hold s_ready", 32'(lsbIf.s_ready), 32'h0);
                checkOutput("bp hold m_data", lsbIf.m_data, 32'h04030201);
                holdLeft--;
            end
            if (lsbIf.m_valid && mr) begin
                checkOutput($sformatf("bp word%0d", words), lsbIf.m_data, expWords[words]);
                checkOutput($sformatf("bp keep%0d", words), 32'(lsbIf.m_keep), 32'hF);
                words++;
            end
            if (lsbIf.s_valid && lsbIf.s_ready) idx++;
            @(posedge clk);
            #1;
        end
        checkOutput("bp word count", 32'(words), 32'd3);
        checkOutput("bp beat count", 32'(idx), 32'd12);
        checkOutput("bp hold cycles", 32'(6 - holdLeft), 32'd6);
        driveInputs(1'b0, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("bp drained m_valid", 32'(lsbIf.m_valid), 32'h0);

        // Reset in the middle of a partial word discards it.
        driveInputs(1'b1, 1'b0, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        driveInputs(1'b1, 1'b0, 8'h02, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        driveInputs(1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        checkOutput("midreset s_ready", 32'(lsbIf.s_ready), 32'h0);
        @(posedge clk);
        #1;
        checkAllZero("midreset");
        rst = 1'b0;
        foreach (resetVecs[i]) applyStimulus(resetVecs[i], $sformatf("rvec%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
